// File: rtl/sync_capture_if.sv
// Pixel stream interface from sync_capture to its sink.
//   data  : pixel word
//   sof   : first pixel of a frame
//   eol   : last pixel of a line
//   valid : word present (source)
//   ready : sink accepts word (sink)
interface sync_capture_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eol;
    logic              valid;
    logic              ready;

    modport master (output data, output sof, output eol, output valid, input ready);
    modport slave  (input data, input sof, input eol, input valid, output ready);
endinterface

// File: rtl/sync_capture.sv
// Captures pixels qualified by HD/VD, tags start-of-frame / end-of-line,
// buffers them in a show-ahead FIFO and measures frame geometry.
//   clk, rst_n          : pixel clock, async active-low reset
//   hd, vd, pix_in      : timing-generator drive pair and pixel bus
//   m (master)          : valid/ready pixel stream with sof/eol markers
//   line_len            : active pixels in last completed line
//   frame_lines         : lines in last completed frame
//   frame_cnt           : completed frames (wraps)
//   overflow, clr_ovf   : sticky drop flag and its clear
module sync_capture #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hd,
    input  logic              vd,
    input  logic [DATA_W-1:0] pix_in,
    sync_capture_if.master    m,
    output logic [CNT_W-1:0]  line_len,
    output logic [CNT_W-1:0]  frame_lines,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              overflow,
    input  logic              clr_ovf
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eol;
    } word_t;

    typedef enum logic {
        S_DISARMED = 1'b0,
        S_ARMED    = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + CNT_W'(1);
    endfunction

    // Stage A: input sampling and VD edge history
    logic              hd_a, vd_a, vd_p;
    logic [DATA_W-1:0] pix_a;
    logic              act_a, vd_rise, vd_fall;

    // vd_a/vd_p reset high so a VD already high at reset release is not a rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd_a  <= 1'b0;
            vd_a  <= 1'b1;
            vd_p  <= 1'b1;
            pix_a <= '0;
        end else begin
            hd_a  <= hd;
            vd_a  <= vd;
            vd_p  <= vd_a;
            pix_a <= pix_in;
        end
    end

    assign act_a   = hd_a & vd_a;
    assign vd_rise = vd_a & ~vd_p;
    assign vd_fall = ~vd_a & vd_p;

    // Arming FSM: disarmed until the first VD rise
    state_t state, state_nxt;
    logic   arm_now_c;
    logic   frame_end_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_DISARMED;
        else        state <= state_nxt;
    end

    // A pixel coincident with the arming rise already belongs to the frame
    always_comb begin
        state_nxt   = state;
        arm_now_c   = 1'b0;
        frame_end_c = 1'b0;
        case (state)
            S_DISARMED: begin
                arm_now_c = vd_rise;
                if (vd_rise) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                arm_now_c   = 1'b1;
                frame_end_c = vd_fall;
            end
            default: state_nxt = S_DISARMED;
        endcase
    end

    // Stage B: hold one pixel until the next sample decides its EOL
    logic              b_vld, b_sof, sof_pending;
    logic [DATA_W-1:0] b_data;
    logic              load;

    assign load = arm_now_c & act_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_vld       <= 1'b0;
            b_sof       <= 1'b0;
            b_data      <= '0;
            sof_pending <= 1'b0;
        end else begin
            b_vld <= load;
            if (load) begin
                b_data <= pix_a;
                b_sof  <= sof_pending | vd_rise;
            end
            if (load)         sof_pending <= 1'b0;
            else if (vd_rise) sof_pending <= 1'b1;
        end
    end

    // Show-ahead FIFO
    word_t          mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           full, empty, push, pop, drop;
    word_t          push_word, head;

    assign push_word = '{data: b_data, sof: b_sof, eol: ~act_a};
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign pop       = ~empty & m.ready;
    assign push      = b_vld & (~full | pop);
    assign drop      = b_vld & ~push;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Head is gated so the stream reads zero whenever nothing is presented
    assign head    = mem[rd_ptr];
    assign m.valid = ~empty;
    assign m.data  = empty ? '0 : head.data;
    assign m.sof   = ~empty & head.sof;
    assign m.eol   = ~empty & head.eol;

    // Sticky overflow; a new drop wins over a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

    // Geometry counters; dropped words still count toward the geometry
    logic [CNT_W-1:0] pix_cnt, line_cnt;
    logic [CNT_W-1:0] pix_inc, lines_now;
    logic             eol_push;

    assign eol_push  = b_vld & ~act_a;
    assign pix_inc   = sat_inc(pix_cnt);
    assign lines_now = eol_push ? sat_inc(line_cnt) : line_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt     <= '0;
            line_cnt    <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            frame_cnt   <= '0;
        end else begin
            if (b_vld) begin
                if (eol_push) begin
                    line_len <= pix_inc;
                    pix_cnt  <= '0;
                end else begin
                    pix_cnt  <= pix_inc;
                end
            end
            // An EOL in the same cycle as the VD fall is included in the frame
            if (frame_end_c) begin
                frame_lines <= lines_now;
                line_cnt    <= '0;
                frame_cnt   <= frame_cnt + CNT_W'(1);
            end else begin
                line_cnt    <= lines_now;
            end
        end
    end

endmodule

// File: tb/tb_sync_capture.sv
// Self-checking bench for sync_capture: a sample-level reference model turns
// the driven HD/VD/pixel sequence into the expected word stream and geometry.
module tb_sync_capture;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 16;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          hd      = 1'b0;
    logic          vd      = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [DW-1:0] pix_in  = '0;
    logic [DW-1:0] pix_ctr = '0;
    logic [CW-1:0] line_len, frame_lines, frame_cnt;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int n_words = 0;

    sync_capture_if #(.DATA_W(DW)) sif ();

    sync_capture #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hd          (hd),
        .vd          (vd),
        .pix_in      (pix_in),
        .m           (sif),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .frame_cnt   (frame_cnt),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (one call per input sample) ----------
    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          eol;
    } word_t;

    word_t exp_q[$];
    word_t m_hold;
    bit    m_have, m_armed, m_sofp, m_prev_vd, m_in_rst;
    int    m_pix, m_lines, e_line_len, e_frame_lines, e_frame_cnt;

    function automatic void model_reset();
        exp_q.delete();
        m_have = 0; m_armed = 0; m_sofp = 0; m_in_rst = 1; m_prev_vd = 1;
        m_pix = 0; m_lines = 0;
        e_line_len = 0; e_frame_lines = 0; e_frame_cnt = 0;
    endfunction

    function automatic void model_step(input bit h, input bit v, input logic [DW-1:0] p);
        bit act;
        act = h & v;
        if (m_in_rst) begin
            m_prev_vd = 1;
            return;
        end
        // a held pixel ends its line when the following sample is inactive
        if (m_have) begin
            m_hold.eol = !act;
            exp_q.push_back(m_hold);
            m_pix++;
            if (!act) begin
                e_line_len = m_pix;
                m_pix = 0;
                m_lines++;
            end
            m_have = 0;
        end
        if (m_armed && !v && m_prev_vd) begin
            e_frame_lines = m_lines;
            m_lines = 0;
            e_frame_cnt = (e_frame_cnt + 1) & 16'hFFFF;
        end
        if (v && !m_prev_vd) begin
            m_armed = 1;
            m_sofp  = 1;
        end
        if (m_armed && act) begin
            m_hold = '{d: p, sof: m_sofp, eol: 1'b0};
            m_have = 1;
            m_sofp = 0;
        end
        m_prev_vd = v;
    endfunction

    // ---------------- stream scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && sif.valid && sif.ready) begin
            word_t w;
            n_tests++;
            n_words++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL stream_word: got data=%0h sof=%0b eol=%0b, required no word",
                         sif.data, sif.sof, sif.eol);
            end else begin
                w = exp_q.pop_front();
                if ({sif.data, sif.sof, sif.eol} !== {w.d, w.sof, w.eol}) begin
                    n_fail++;
                    $display("FAIL stream_word: got data=%0h sof=%0b eol=%0b, required data=%0h sof=%0b eol=%0b",
                             sif.data, sif.sof, sif.eol, w.d, w.sof, w.eol);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit h, input bit v, input bit rdy);
        @(posedge clk);
        #1;
        hd        = h;
        vd        = v;
        sif.ready = rdy;
        pix_in    = pix_ctr;
        pix_ctr   = pix_ctr + 8'd1;
        model_step(h, v, pix_in);
    endtask

    // 64-cycle lines, HD high on cycles 4..60, VD high for lines 0..30
    task automatic nom_cycle(input int l, input int c, input bit rdy);
        step((c >= 4) && (c < 61), l < 31, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !sif.valid && !m_have) break;
            step(1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic release_reset();
        rst_n    = 1'b1;
        m_in_rst = 0;
        model_step(hd, vd, pix_in);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sif.ready = 1'b0;
        model_reset();
        #12;
        n_tests++; if (sif.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b, required 0", sif.valid); end
        n_tests++; if (sif.data !== '0) begin n_fail++; $display("FAIL rst_data: got %0h, required 0", sif.data); end
        n_tests++; if (sif.sof !== 1'b0 || sif.eol !== 1'b0) begin n_fail++; $display("FAIL rst_markers: got sof=%0b eol=%0b, required 0 0", sif.sof, sif.eol); end
        n_tests++; if (line_len !== '0 || frame_lines !== '0 || frame_cnt !== '0) begin n_fail++; $display("FAIL rst_counters: got %0d %0d %0d, required 0 0 0", line_len, frame_lines, frame_cnt); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0b, required 0", overflow); end
        @(posedge clk);
        #1;
        release_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_nominal();
        int w0;
        w0 = n_words;
        for (int f = 0; f < 2; f++) begin
            for (int l = 0; l < 32; l++)
                for (int c = 0; c < 64; c++)
                    nom_cycle(l, c, 1'b1);
            n_tests++; if (line_len !== 16'd57) begin n_fail++; $display("FAIL nom_line_len: got %0d, required 57", line_len); end
            n_tests++; if (frame_lines !== 16'd31) begin n_fail++; $display("FAIL nom_frame_lines: got %0d, required 31", frame_lines); end
            n_tests++; if (frame_cnt !== 16'(e_frame_cnt)) begin n_fail++; $display("FAIL nom_frame_cnt: got %0d, required %0d", frame_cnt, e_frame_cnt); end
        end
        drain();
        n_tests++; if (n_words - w0 != 2 * 57 * 31) begin n_fail++; $display("FAIL nom_word_count: got %0d, required %0d", n_words - w0, 2 * 57 * 31); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL nom_overflow: got %0b, required 0", overflow); end
    endtask

    task automatic test_overflow();
        logic [DW+1:0] held;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %0b, required 0", overflow); end
        for (int i = 0; i < 47; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
        n_tests++; if (overflow !== 1'b1 || sif.valid !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got overflow=%0b valid=%0b, required 1 1", overflow, sif.valid); end
        n_tests++; if (dut.count !== 5'd16) begin n_fail++; $display("FAIL ovf_held_words: got %0d, required 16", dut.count); end
        @(negedge clk);
        held = {sif.data, sif.sof, sif.eol};
        step(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        n_tests++; if ({sif.data, sif.sof, sif.eol} !== held) begin n_fail++; $display("FAIL ovf_stable: got %0h, required %0h", {sif.data, sif.sof, sif.eol}, held); end
        // only the first 16 pixels of the line survive
        while (exp_q.size() > 16) void'(exp_q.pop_back());
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        n_tests++; if (line_len !== 16'd57) begin n_fail++; $display("FAIL ovf_line_len: got %0d, required 57", line_len); end
        drain();
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_drain: %0d words outstanding, required 0", exp_q.size()); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b, required 1", overflow); end
        clr_ovf = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        clr_ovf = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b, required 0", overflow); end
    endtask

    task automatic test_random_bp();
        for (int l = 0; l < 6; l++)
            for (int c = 0; c < 16; c++)
                step((c >= 1) && (c < 9), l < 5, 1'($urandom_range(0, 1)));
        drain();
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rbp_drain: %0d words outstanding, required 0", exp_q.size()); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rbp_overflow: got %0b, required 0", overflow); end
        n_tests++; if (line_len !== 16'd8 || frame_lines !== 16'd5) begin n_fail++; $display("FAIL rbp_geometry: got line_len=%0d frame_lines=%0d, required 8 5", line_len, frame_lines); end
    endtask

    task automatic test_midline_vd();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b1);
            for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        n_tests++; if (line_len !== 16'd20) begin n_fail++; $display("FAIL mid_line_len: got %0d, required 20", line_len); end
        n_tests++; if (frame_lines !== 16'd3) begin n_fail++; $display("FAIL mid_frame_lines: got %0d, required 3", frame_lines); end
        n_tests++; if (frame_cnt !== 16'(e_frame_cnt)) begin n_fail++; $display("FAIL mid_frame_cnt: got %0d, required %0d", frame_cnt, e_frame_cnt); end
        drain();
    endtask

    task automatic test_reset_mid();
        for (int l = 0; l < 10; l++)
            for (int c = 0; c < 64; c++)
                nom_cycle(l, c, 1'b1);
        for (int c = 0; c < 30; c++) nom_cycle(10, c, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++; if (sif.valid !== 1'b0 || sif.data !== '0 || sif.sof !== 1'b0 || sif.eol !== 1'b0) begin n_fail++; $display("FAIL rmid_stream: got valid=%0b data=%0h sof=%0b eol=%0b, required all 0", sif.valid, sif.data, sif.sof, sif.eol); end
        n_tests++; if (line_len !== '0 || frame_lines !== '0 || frame_cnt !== '0 || overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_status: got %0d %0d %0d %0b, required 0 0 0 0", line_len, frame_lines, frame_cnt, overflow); end
        for (int c = 30; c < 33; c++) nom_cycle(10, c, 1'b1);
        release_reset();
        for (int c = 33; c < 64; c++) nom_cycle(10, c, 1'b1);
        for (int l = 11; l < 32; l++)
            for (int c = 0; c < 64; c++)
                nom_cycle(l, c, 1'b1);
        n_tests++; if (frame_cnt !== 16'd0 || line_len !== 16'd0) begin n_fail++; $display("FAIL rmid_discard: got frame_cnt=%0d line_len=%0d, required 0 0", frame_cnt, line_len); end
        for (int l = 0; l < 32; l++)
            for (int c = 0; c < 64; c++)
                nom_cycle(l, c, 1'b1);
        drain();
        n_tests++; if (frame_cnt !== 16'd1 || frame_lines !== 16'd31) begin n_fail++; $display("FAIL rmid_next_frame: got frame_cnt=%0d frame_lines=%0d, required 1 31", frame_cnt, frame_lines); end
    endtask

    task automatic test_single_px();
        drain();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (sif.valid !== 1'b0) begin n_fail++; $display("FAIL px1_latency_early: got valid=%0b, required 0", sif.valid); end
        @(negedge clk);
        n_tests++; if (sif.valid !== 1'b1 || sif.sof !== 1'b1 || sif.eol !== 1'b1) begin n_fail++; $display("FAIL px1_word: got valid=%0b sof=%0b eol=%0b, required 1 1 1", sif.valid, sif.sof, sif.eol); end
        n_tests++; if (line_len !== 16'd1) begin n_fail++; $display("FAIL px1_line_len: got %0d, required 1", line_len); end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        n_tests++; if (frame_lines !== 16'd1) begin n_fail++; $display("FAIL px1_frame_lines: got %0d, required 1", frame_lines); end
        // a frame with no active pixels
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        n_tests++; if (frame_lines !== 16'd0) begin n_fail++; $display("FAIL empty_frame_lines: got %0d, required 0", frame_lines); end
        n_tests++; if (frame_cnt !== 16'(e_frame_cnt)) begin n_fail++; $display("FAIL empty_frame_cnt: got %0d, required %0d", frame_cnt, e_frame_cnt); end
        n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL px1_drain: %0d words outstanding, required 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_overflow();
        test_random_bp();
        test_midline_vd();
        test_reset_mid();
        test_single_px();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
